mem_stage_ctrl: RTL and testbench

Memory-stage controller that consumes the EX/M pipeline register outputs, performs load/store accesses on a variable-latency data-memory port with a req/ready handshake, selects the write-back result, and registers it toward the M/WB stage. While an access is outstanding it asserts a combinational stall that freezes the EX/M register (drives its `enable` low) and emits bubbles downstream. It sits between `EX_M_reg` and the M/WB register in the superscalar pipeline, one instance per memory-capable lane.

---
 rtl/iitb_pipe_pkg.sv | 14 +
 rtl/mem_result_mux.sv | 25 ++
 rtl/mem_stage_ctrl.sv | 119 +++++++++++
 tb/tb_mem_stage_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/iitb_pipe_pkg.sv
// Shared pipeline definitions: result-select codes, Memory field bits, MEM FSM states.
package iitb_pipe_pkg;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_MEM  = 2'b01;
  localparam logic [1:0] SEL_PC2  = 2'b10;
  localparam logic [1:0] SEL_ZPAD = 2'b11;

  localparam int unsigned MEM_LOAD_BIT  = 1;
  localparam int unsigned MEM_STORE_BIT = 0;

  typedef enum logic {IDLE, BUSY} mem_state_t;

endpackage

// File: rtl/mem_result_mux.sv
// Combinational 4:1 write-back result select, shared with the M/WB forwarding path.
module mem_result_mux
  import iitb_pipe_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [15:0] alu,
  input  logic [15:0] load_data,
  input  logic [15:0] pc_plus2,
  input  logic [15:0] zero_pad,
  output logic [15:0] result
);

  // Pick the write-back source from WB[2:1]
  always_comb begin
    result = alu;
    case (sel)
      SEL_ALU:  result = alu;
      SEL_MEM:  result = load_data;
      SEL_PC2:  result = pc_plus2;
      SEL_ZPAD: result = zero_pad;
      default:  result = alu;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: launches data-memory accesses, stalls EX/M while they
// are outstanding, and registers the selected write-back result toward M/WB.
module mem_stage_ctrl
  import iitb_pipe_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] PC_plus2_in,
  input  logic [2:0]  WB_in,
  input  logic [1:0]  Memory_in,
  input  logic [15:0] Store_data_in,
  input  logic [15:0] ALU_in,
  input  logic [15:0] Zero_pad_in,
  input  logic [2:0]  Dest_in,
  input  logic        Valid_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [15:0] Result_out,
  output logic [2:0]  WB_out,
  output logic [2:0]  Dest_out,
  output logic        Valid_out,
  output logic        mem_err,
  output logic [15:0] stall_count
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  mem_state_t    state;
  logic [CW-1:0] tcnt;
  logic          mem_op;
  logic          timeout_hit;
  logic          complete;
  logic [15:0]   load_data;
  logic [15:0]   sel_result;

  // Decode memory op, timeout and stall; no path from dmem_rdata into stall
  always_comb begin
    mem_op      = Valid_in & (Memory_in != 2'b00);
    timeout_hit = (state == BUSY) && !dmem_ready && (tcnt == CW'(TIMEOUT - 1));
    complete    = (state == BUSY) && (dmem_ready || timeout_hit);
    stall_out   = (state == IDLE) ? mem_op : (!dmem_ready && !timeout_hit);
    load_data   = '0;
    if ((state == BUSY) && dmem_ready && !dmem_we)
      load_data = dmem_rdata;
  end

  mem_result_mux u_mux (
    .sel       (WB_in[2:1]),
    .alu       (ALU_in),
    .load_data (load_data),
    .pc_plus2  (PC_plus2_in),
    .zero_pad  (Zero_pad_in),
    .result    (sel_result)
  );

  // FSM, access registers, M/WB outputs, timeout and stall counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      tcnt        <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      Result_out  <= '0;
      WB_out      <= '0;
      Dest_out    <= '0;
      Valid_out   <= 1'b0;
      mem_err     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (stall_out && (stall_count != '1))
        stall_count <= stall_count + 16'd1;
      case (state)
        IDLE: begin
          if (mem_op) begin
            dmem_addr  <= ALU_in;
            dmem_wdata <= Store_data_in;
            dmem_we    <= Memory_in[MEM_STORE_BIT];
            dmem_req   <= 1'b1;
            tcnt       <= '0;
            Valid_out  <= 1'b0;
            state      <= BUSY;
          end else begin
            Result_out <= sel_result;
            WB_out     <= WB_in;
            Dest_out   <= Dest_in;
            Valid_out  <= Valid_in;
          end
        end
        BUSY: begin
          if (complete) begin
            // EX/M is frozen during BUSY, so its live fields still belong to this op
            Result_out <= sel_result;
            WB_out     <= WB_in;
            Dest_out   <= Dest_in;
            Valid_out  <= 1'b1;
            dmem_req   <= 1'b0;
            state      <= IDLE;
            if (timeout_hit)
              mem_err <= 1'b1;
          end else begin
            tcnt      <= tcnt + CW'(1);
            Valid_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: driver pushes expected results, monitor pops on Valid_out.
module tb_mem_stage_ctrl;

  localparam int unsigned T = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] PC_plus2_in, Store_data_in, ALU_in, Zero_pad_in, dmem_rdata;
  logic [2:0]  WB_in, Dest_in;
  logic [1:0]  Memory_in;
  logic        Valid_in, dmem_ready;
  logic        stall_out, dmem_req, dmem_we, Valid_out, mem_err;
  logic [15:0] dmem_addr, dmem_wdata, Result_out, stall_count;
  logic [2:0]  WB_out, Dest_out;

  mem_stage_ctrl #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .PC_plus2_in(PC_plus2_in), .WB_in(WB_in),
    .Memory_in(Memory_in), .Store_data_in(Store_data_in), .ALU_in(ALU_in),
    .Zero_pad_in(Zero_pad_in), .Dest_in(Dest_in), .Valid_in(Valid_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .Result_out(Result_out), .WB_out(WB_out),
    .Dest_out(Dest_out), .Valid_out(Valid_out), .mem_err(mem_err),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  wb;
    logic [2:0]  dest;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] sc_exp  = '0;
  bit          err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one instruction into EX/M; for memory ops, ready arrives after d BUSY wait cycles
  task automatic issue(input bit v, input logic [1:0] mem, input logic [2:0] wb,
                       input logic [15:0] alu, input logic [15:0] sd, input logic [15:0] pc2,
                       input logic [15:0] zp, input logic [2:0] dest,
                       input int unsigned d, input logic [15:0] rdata);
    bit          ismem;
    logic [15:0] ld, res;
    int unsigned lim;
    @(negedge clock);
    chk("dmem_req_idle", dmem_req, 1'b0);
    chk("stall_count", stall_count, sc_exp);
    chk("mem_err", mem_err, err_exp);
    Valid_in = v; Memory_in = mem; WB_in = wb; ALU_in = alu; Store_data_in = sd;
    PC_plus2_in = pc2; Zero_pad_in = zp; Dest_in = dest;
    dmem_ready = 1'($urandom);
    dmem_rdata = 16'($urandom);
    ismem = v && (mem != 2'b00);
    ld = (ismem && !mem[0] && d < T) ? rdata : 16'h0000;
    case (wb[2:1])
      2'b00:   res = alu;
      2'b01:   res = ld;
      2'b10:   res = pc2;
      default: res = zp;
    endcase
    if (v) sb.push_back('{res: res, wb: wb, dest: dest});
    #1;
    chk("stall_idle", stall_out, ismem);
    if (ismem && sc_exp != 16'hFFFF) sc_exp++;
    if (ismem) begin
      lim = (d < T - 1) ? d : T - 1;
      for (int unsigned k = 0; k < T; k++) begin
        @(negedge clock);
        dmem_ready = (k == d);
        dmem_rdata = (k == d) ? rdata : 16'($urandom);
        #1;
        chk("dmem_req", dmem_req, 1'b1);
        chk("dmem_we", dmem_we, mem[0]);
        chk("dmem_addr", dmem_addr, alu);
        if (mem[0]) chk("dmem_wdata", dmem_wdata, sd);
        chk("bubble", Valid_out, 1'b0);
        chk("stall_busy", stall_out, k < lim);
        if (k < lim && sc_exp != 16'hFFFF) sc_exp++;
        if (k == lim) begin
          if (d >= T) err_exp = 1'b1;
          break;
        end
      end
    end
  endtask

  // Monitor: every valid M/WB output must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset === 1'b1 && Valid_out === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("Result_out", Result_out, e.res);
          chk("WB_out", WB_out, e.wb);
          chk("Dest_out", Dest_out, e.dest);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b0; Valid_in = 0; Memory_in = 0; WB_in = 0; ALU_in = 0; Store_data_in = 0;
    PC_plus2_in = 0; Zero_pad_in = 0; Dest_in = 0; dmem_ready = 0; dmem_rdata = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_Result", Result_out, 0);  chk("rst_WB", WB_out, 0);
    chk("rst_Dest", Dest_out, 0);      chk("rst_Valid", Valid_out, 0);
    chk("rst_req", dmem_req, 0);       chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);     chk("rst_wdata", dmem_wdata, 0);
    chk("rst_err", mem_err, 0);        chk("rst_scount", stall_count, 0);
    reset = 1'b1;

    // ALU op, load with 3 wait cycles, store ready at once, timeout load
    issue(1, 2'b00, 3'b001, 16'h1234, 16'h0, 16'h0002, 16'h0007, 3'd1, 0, 16'h0);
    issue(1, 2'b10, 3'b011, 16'h0040, 16'h0, 16'h0004, 16'h0009, 3'd2, 3, 16'hBEEF);
    issue(0, 2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
    chk("stall_count_load", stall_count, 16'd4);
    issue(1, 2'b01, 3'b000, 16'h0010, 16'hA5A5, 16'h0006, 16'h0, 3'd3, 0, 16'h0);
    issue(1, 2'b10, 3'b011, 16'h0080, 16'h0, 16'h0008, 16'h0, 3'd4, 99, 16'h5555);
    issue(1, 2'b00, 3'b101, 16'h0, 16'h0, 16'h000A, 16'h0, 3'd5, 0, 16'h0);
    chk("mem_err_sticky", mem_err, 1'b1);
    // Back-to-back loads, each ready in the first BUSY cycle; Memory_in=11 acts as a store
    issue(1, 2'b10, 3'b011, 16'h0100, 16'h0, 16'h0, 16'h0, 3'd6, 0, 16'h1111);
    issue(1, 2'b10, 3'b011, 16'h0102, 16'h0, 16'h0, 16'h0, 3'd7, 0, 16'h2222);
    issue(1, 2'b11, 3'b011, 16'h0104, 16'h7777, 16'h0, 16'h0, 3'd1, 1, 16'h3333);

    // Reset in the middle of an outstanding load
    issue(0, 2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
    @(negedge clock);
    Valid_in = 1; Memory_in = 2'b10; WB_in = 3'b011; ALU_in = 16'h0200; dmem_ready = 0;
    repeat (2) begin @(negedge clock); dmem_ready = 0; end
    #1 chk("pre_abort_req", dmem_req, 1'b1);
    reset = 1'b0; Valid_in = 0; Memory_in = 0;
    @(negedge clock);
    chk("abort_req", dmem_req, 0);     chk("abort_Valid", Valid_out, 0);
    chk("abort_Result", Result_out, 0); chk("abort_err", mem_err, 0);
    chk("abort_scount", stall_count, 0); chk("abort_addr", dmem_addr, 0);
    #1 chk("abort_stall", stall_out, 0);
    reset = 1'b1; sc_exp = '0; err_exp = 1'b0;

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      issue($urandom_range(0, 7) != 0, 2'($urandom), 3'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom),
            $urandom_range(0, 5), 16'($urandom));
    end
    repeat (2) issue(0, 2'b00, 3'b000, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
